io_conditioner: RTL and testbench



---
 rtl/io_conditioner.sv | 147 ++++++++++++++
 tb/tb_io_conditioner.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/io_conditioner.sv
// Raw pin front-end: per-channel synchroniser, polarity normalisation, debounce,
// rise/fall pulses. Auto-repeat pulses are built only when IO_COND_REPEAT_EN is defined.
module io_conditioner #(
  parameter int unsigned         CHANNELS        = 12,
  parameter int unsigned         SYNC_STAGES     = 2,
  parameter int unsigned         DEBOUNCE_CYCLES = 500000,
  parameter logic [CHANNELS-1:0] ACTIVE_LOW_MASK = CHANNELS'(12'h003),
  parameter int unsigned         REPEAT_DELAY    = 25000000,
  parameter int unsigned         REPEAT_PERIOD   = 5000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] pin_i,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] rpt,
  output logic                event_any
);

  localparam int unsigned    CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {STABLE, PENDING} db_state_t;

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1)
  begin : g_bad_param
    $error("io_conditioner: illegal parameter value");
  end

  logic [CHANNELS-1:0] pin_n;
  logic [CHANNELS-1:0] s;
  logic [CHANNELS-1:0] acc_rise;
  logic [CHANNELS-1:0] acc_fall;
  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  db_state_t           state  [CHANNELS];
  logic [CW-1:0]       cnt    [CHANNELS];

  // Inversion happens before the first flop so the chain resets to "inactive".
  assign pin_n = pin_i ^ ACTIVE_LOW_MASK;
  assign s     = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= pin_n;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  // A change is accepted on the DEBOUNCE_CYCLES-th consecutive differing sample.
  always_comb begin
    acc_rise = '0;
    acc_fall = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (s[i] != level[i]) begin
        if ((state[i] == PENDING) ? (cnt[i] == CNT_LAST) : (DEBOUNCE_CYCLES == 1)) begin
          acc_rise[i] = s[i];
          acc_fall[i] = ~s[i];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= '0;
      rise  <= '0;
      fall  <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        state[i] <= STABLE;
        cnt[i]   <= '0;
      end
    end else begin
      level <= level ^ (acc_rise | acc_fall);
      rise  <= acc_rise;
      fall  <= acc_fall;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        case (state[i])
          STABLE: begin
            if (s[i] != level[i] && !(acc_rise[i] || acc_fall[i])) begin
              state[i] <= PENDING;
              cnt[i]   <= CW'(1);
            end
          end
          PENDING: begin
            if (s[i] == level[i] || acc_rise[i] || acc_fall[i]) begin
              state[i] <= STABLE;
              cnt[i]   <= '0;
            end else begin
              cnt[i] <= cnt[i] + CW'(1);
            end
          end
          default: begin
            state[i] <= STABLE;
            cnt[i]   <= '0;
          end
        endcase
      end
    end
  end

`ifdef IO_COND_REPEAT_EN
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] R_FIRST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] R_NEXT  = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0]       rcnt [CHANNELS];
  logic [CHANNELS-1:0] rep_on;
  logic [CHANNELS-1:0] rep_first;

  // rcnt counts cycles since the last rise/repeat pulse; the level-change edge never fires rpt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt       <= '0;
      rep_on    <= '0;
      rep_first <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) rcnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        rpt[i] <= 1'b0;
        if (acc_rise[i]) begin
          rep_on[i]    <= 1'b1;
          rep_first[i] <= 1'b1;
          rcnt[i]      <= '0;
        end else if (acc_fall[i] || !rep_on[i]) begin
          rep_on[i] <= 1'b0;
          rcnt[i]   <= '0;
        end else if (rcnt[i] == (rep_first[i] ? R_FIRST : R_NEXT)) begin
          rpt[i]       <= 1'b1;
          rep_first[i] <= 1'b0;
          rcnt[i]      <= '0;
        end else begin
          rcnt[i] <= rcnt[i] + RW'(1);
        end
      end
    end
  end
`else
  assign rpt = '0;
`endif

  assign event_any = |(rise | fall | rpt);

endmodule

// File: tb/tb_io_conditioner.sv
// Directed bench for io_conditioner: expected pulses are queued with their due cycle
// when stimulus is driven, and every cycle is checked against the queue head or "quiet".
module tb_io_conditioner;

  localparam int CH = 12;
  localparam logic [CH-1:0] IDLE = 12'h003;

  typedef struct {
    int            at;
    string         tag;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    logic [CH-1:0] rpt;
    logic [CH-1:0] level;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] pin_i;
  logic [CH-1:0] level, rise, fall, rpt;
  logic          event_any;

  ev_t           sb[$];
  int            cyc = 0;
  int            n_tests = 0;
  int            n_fail = 0;
  logic [CH-1:0] cur_level;

  io_conditioner #(
    .CHANNELS        (CH),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .ACTIVE_LOW_MASK (12'h003),
    .REPEAT_DELAY    (20),
    .REPEAT_PERIOD   (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pin_i     (pin_i),
    .level     (level),
    .rise      (rise),
    .fall      (fall),
    .rpt       (rpt),
    .event_any (event_any)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int delay, input logic [CH-1:0] r,
                      input logic [CH-1:0] f, input logic [CH-1:0] p, input logic [CH-1:0] l);
    sb.push_back('{at: cyc + delay, tag: tag, rise: r, fall: f, rpt: p, level: l});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_level"}, level, '0);
    check({tag, "_rise"},  rise,  '0);
    check({tag, "_fall"},  fall,  '0);
    check({tag, "_rpt"},   rpt,   '0);
    check({tag, "_any"},   CH'(event_any), '0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (sb.size() > 0 && sb[0].at == cyc) begin
      ev_t e;
      e = sb.pop_front();
      check({e.tag, "_rise"},  rise,  e.rise);
      check({e.tag, "_fall"},  fall,  e.fall);
      check({e.tag, "_rpt"},   rpt,   e.rpt);
      check({e.tag, "_level"}, level, e.level);
      check({e.tag, "_any"},   CH'(event_any), CH'(|(e.rise | e.fall | e.rpt)));
      cur_level = e.level;
    end else begin
      check("quiet_rise",  rise,  '0);
      check("quiet_fall",  fall,  '0);
      check("quiet_rpt",   rpt,   '0);
      check("quiet_level", level, cur_level);
      check("quiet_any",   CH'(event_any), '0);
    end
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    rst       = 1'b1;
    pin_i     = IDLE;
    cur_level = '0;
    @(posedge clk);
    #1;
    check_all_zero("reset");
    ticks(2);
    rst = 1'b0;
    ticks(6);

    // Clean press/release on active-low channel 0.
    pin_i[0] = 1'b0;
    push("press0", 6, 12'h001, '0, '0, 12'h001);
    ticks(8);
    pin_i[0] = 1'b1;
    push("release0", 6, '0, 12'h001, '0, '0);
    ticks(10);

    // Three-cycle glitch on channel 5 must be swallowed.
    pin_i[5] = 1'b1;
    ticks(3);
    pin_i[5] = 1'b0;
    ticks(10);

    // Bounce on channel 7, settling high on the fifth toggle.
    for (int k = 0; k < 5; k++) begin
      pin_i[7] = (k % 2 == 0);
      if (k == 4) push("bounce7", 6, 12'h080, '0, '0, 12'h080);
      ticks(2);
    end
    ticks(6);
    pin_i[7] = 1'b0;
    push("release7", 6, '0, 12'h080, '0, '0);
    ticks(10);

    // Channel 0 press and channel 5 release on the same edge.
    pin_i[5] = 1'b1;
    push("press5", 6, 12'h020, '0, '0, 12'h020);
    ticks(8);
    pin_i[0] = 1'b0;
    pin_i[5] = 1'b0;
    push("simul", 6, 12'h001, 12'h020, '0, 12'h001);
    ticks(8);
    pin_i[0] = 1'b1;
    push("release0b", 6, '0, 12'h001, '0, '0);
    ticks(10);

    // Reset while channel 9 is active and channel 3 is mid-count.
    pin_i[9] = 1'b1;
    push("press9", 6, 12'h200, '0, '0, 12'h200);
    ticks(7);
    pin_i[3] = 1'b1;
    ticks(4);
    rst       = 1'b1;
    cur_level = '0;
    #1;
    check_all_zero("rst_async");
    pin_i[9] = 1'b0;
    ticks(3);
    rst = 1'b0;
    push("rst_rise3", 6, 12'h008, '0, '0, 12'h008);
    ticks(8);
    pin_i[3] = 1'b0;
    push("release3", 6, '0, 12'h008, '0, '0);
    ticks(10);

    // Long hold on active-low channel 1.
    pin_i[1] = 1'b0;
    push("press1", 6, 12'h002, '0, '0, 12'h002);
`ifdef IO_COND_REPEAT_EN
    push("rpt1_a", 26, '0, '0, 12'h002, 12'h002);
    push("rpt1_b", 34, '0, '0, 12'h002, 12'h002);
    push("rpt1_c", 42, '0, '0, 12'h002, 12'h002);
`endif
    ticks(41);
    pin_i[1] = 1'b1;
    push("release1", 6, '0, 12'h002, '0, '0);
    ticks(30);

    check("sb_empty", CH'(sb.size()), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
